// File: rtl/pixel_pkg.sv
// Shared types and default dimensions for the pixel stream consumer path.
package pixel_pkg;

   localparam int unsigned DEF_DATA_WIDTH   = 32;
   localparam int unsigned DEF_RBG_SIZE     = 24;
   localparam int unsigned DEF_IMAGE_WIDTH  = 640;
   localparam int unsigned DEF_IMAGE_HEIGHT = 480;

   typedef enum logic {
      WAIT_SOF,
      ACTIVE
   } sink_state_t;

   typedef struct packed {
      logic [DEF_RBG_SIZE-1:0] colour;
      logic                    first;
      logic                    last_x;
      logic                    last_y;
   } pixel_beat_t;

endpackage

// File: rtl/pixel_position_counter.sv
// Tracks the (x, y) position and the linear frame buffer address of the next pixel.
module pixel_position_counter
   import pixel_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
   parameter int unsigned IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
   parameter int unsigned ADDR_WIDTH   = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  advance_i,
   input  logic                  restart_i,
   input  logic                  force_nl_i,
   output logic [DATA_WIDTH-1:0] x_o,
   output logic [DATA_WIDTH-1:0] y_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  eol_o,
   output logic                  eof_o,
   output logic                  at_origin_o
);

   localparam logic [DATA_WIDTH-1:0] LAST_X = DATA_WIDTH'(IMAGE_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] LAST_Y = DATA_WIDTH'(IMAGE_HEIGHT - 1);
   localparam logic [DATA_WIDTH-1:0] ONE_D  = DATA_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] LINE_A = ADDR_WIDTH'(IMAGE_WIDTH);

   logic [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, cur_x, cur_y;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, base_q, base_d, cur_addr, cur_base;

   // A restarting beat takes position (0,0) before the advance is applied to it.
   always_comb begin
      cur_x    = restart_i ? '0 : x_q;
      cur_y    = restart_i ? '0 : y_q;
      cur_addr = restart_i ? '0 : addr_q;
      cur_base = restart_i ? '0 : base_q;
      eol_o    = (cur_x == LAST_X);
      eof_o    = eol_o && (cur_y == LAST_Y);

      x_d    = x_q;
      y_d    = y_q;
      addr_d = addr_q;
      base_d = base_q;
      if (advance_i) begin
         if (eof_o) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
            base_d = '0;
         end else if (eol_o || force_nl_i) begin
            x_d    = '0;
            y_d    = cur_y + ONE_D;
            base_d = cur_base + LINE_A;
            addr_d = cur_base + LINE_A;
         end else begin
            x_d    = cur_x + ONE_D;
            y_d    = cur_y;
            addr_d = cur_addr + ONE_A;
            base_d = cur_base;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q    <= '0;
         y_q    <= '0;
         addr_q <= '0;
         base_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         addr_q <= addr_d;
         base_q <= base_d;
      end
   end

   assign x_o         = cur_x;
   assign y_o         = cur_y;
   assign addr_o      = cur_addr;
   assign at_origin_o = (x_q == '0) && (y_q == '0);

endmodule

// File: rtl/pixel_stream_sink.sv
// Consumer end of the pixel stream: checks framing and writes pixels to a linear frame buffer.
module pixel_stream_sink
   import pixel_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned RBG_SIZE     = DEF_RBG_SIZE,
   parameter int unsigned IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
   parameter int unsigned IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
   parameter int unsigned ADDR_WIDTH   = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [RBG_SIZE-1:0]   colour_i,
   input  logic                  first,
   input  logic                  last_x,
   input  logic                  last_y,
   input  logic                  valid,
   output logic                  ready,
   input  logic                  wr_full,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [RBG_SIZE-1:0]   wr_data,
   output logic [DATA_WIDTH-1:0] xpixel_o,
   output logic [DATA_WIDTH-1:0] ypixel_o,
   output logic                  frame_done,
   output logic                  err_sof,
   output logic                  err_eol,
   output logic [15:0]           frame_count
);

   sink_state_t state_q, state_d;

   logic                  accept, write, restart, force_nl;
   logic                  sof_err_d, eol_err_d, done_d;
   logic [DATA_WIDTH-1:0] pos_x, pos_y;
   logic [ADDR_WIDTH-1:0] pos_addr;
   logic                  pos_eol, pos_eof, pos_origin;

   logic                  wr_en_q, frame_done_q, err_sof_q, err_eol_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [RBG_SIZE-1:0]   wr_data_q;
   logic [DATA_WIDTH-1:0] xpixel_q, ypixel_q;
   logic [15:0]           frame_count_q;

   assign ready  = !wr_full && reset;
   assign accept = valid && ready;

   pixel_position_counter #(
      .DATA_WIDTH   (DATA_WIDTH),
      .IMAGE_WIDTH  (IMAGE_WIDTH),
      .IMAGE_HEIGHT (IMAGE_HEIGHT),
      .ADDR_WIDTH   (ADDR_WIDTH)
   ) u_pos (
      .clk         (clk),
      .reset       (reset),
      .advance_i   (write),
      .restart_i   (restart),
      .force_nl_i  (force_nl),
      .x_o         (pos_x),
      .y_o         (pos_y),
      .addr_o      (pos_addr),
      .eol_o       (pos_eol),
      .eof_o       (pos_eof),
      .at_origin_o (pos_origin)
   );

   // Reaching the final position always ends the frame; only a correctly framed beat counts it.
   always_comb begin
      state_d   = state_q;
      write     = 1'b0;
      restart   = 1'b0;
      force_nl  = 1'b0;
      sof_err_d = 1'b0;
      eol_err_d = 1'b0;
      done_d    = 1'b0;

      if (accept) begin
         if (state_q == ACTIVE) write = 1'b1;
         else                   write = first;
      end

      if (write) begin
         restart   = first;
         force_nl  = last_x && !pos_eol;
         sof_err_d = first && (state_q == ACTIVE) && !pos_origin;
         eol_err_d = (last_x != pos_eol) || (pos_eof && !last_y);
         done_d    = pos_eof && last_x && last_y;
         state_d   = pos_eof ? WAIT_SOF : ACTIVE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= WAIT_SOF;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         xpixel_q      <= '0;
         ypixel_q      <= '0;
         frame_done_q  <= 1'b0;
         err_sof_q     <= 1'b0;
         err_eol_q     <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q      <= state_d;
         wr_en_q      <= write;
         frame_done_q <= done_d;
         err_sof_q    <= sof_err_d;
         err_eol_q    <= eol_err_d;
         if (write) begin
            wr_addr_q <= pos_addr;
            wr_data_q <= colour_i;
            xpixel_q  <= pos_x;
            ypixel_q  <= pos_y;
         end
         if (done_d) frame_count_q <= frame_count_q + 16'd1;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign xpixel_o    = xpixel_q;
   assign ypixel_o    = ypixel_q;
   assign frame_done  = frame_done_q;
   assign err_sof     = err_sof_q;
   assign err_eol     = err_eol_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Directed bench for pixel_stream_sink on a 4x3 image with a write scoreboard.
module tb_pixel_stream_sink;
   import pixel_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 24;
   localparam int unsigned W  = 4;
   localparam int unsigned H  = 3;
   localparam int unsigned AW = $clog2(W*H);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] colour = '0;
   logic          first = 1'b0, last_x = 1'b0, last_y = 1'b0, valid = 1'b0;
   logic          ready, wr_full = 1'b0, wr_en;
   logic [AW-1:0] wr_addr;
   logic [CW-1:0] wr_data;
   logic [DW-1:0] xpixel, ypixel;
   logic          frame_done, err_sof, err_eol;
   logic [15:0]   frame_count;

   typedef struct {
      int unsigned   addr;
      logic [CW-1:0] data;
      int unsigned   x;
      int unsigned   y;
      bit            done;
      bit            sof;
      bit            eol;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pixel_stream_sink #(
      .DATA_WIDTH   (DW),
      .RBG_SIZE     (CW),
      .IMAGE_WIDTH  (W),
      .IMAGE_HEIGHT (H),
      .ADDR_WIDTH   (AW)
   ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .colour_i    (colour),
      .first       (first),
      .last_x      (last_x),
      .last_y      (last_y),
      .valid       (valid),
      .ready       (ready),
      .wr_full     (wr_full),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .xpixel_o    (xpixel),
      .ypixel_o    (ypixel),
      .frame_done  (frame_done),
      .err_sof     (err_sof),
      .err_eol     (err_eol),
      .frame_count (frame_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at every negedge: a write must appear exactly one cycle after its accept.
   task automatic check_out();
      exp_t e;
      chk("wr_en", 32'(wr_en), 32'(sb.size() != 0));
      if (wr_en === 1'b1 && sb.size() != 0) begin
         e = sb.pop_front();
         chk("wr_addr",    32'(wr_addr),    32'(e.addr));
         chk("wr_data",    32'(wr_data),    32'(e.data));
         chk("xpixel",     xpixel,          32'(e.x));
         chk("ypixel",     ypixel,          32'(e.y));
         chk("frame_done", 32'(frame_done), 32'(e.done));
         chk("err_sof",    32'(err_sof),    32'(e.sof));
         chk("err_eol",    32'(err_eol),    32'(e.eol));
      end else if (wr_en !== 1'b1) begin
         chk("idle_pulses", 32'({frame_done, err_sof, err_eol}), 32'd0);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check_out();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input pixel_beat_t b, input int stall, input bit wr,
                       input int unsigned ea, input int unsigned ex, input int unsigned ey,
                       input bit ed, input bit es, input bit ee);
      exp_t e;
      colour = b.colour;
      first  = b.first;
      last_x = b.last_x;
      last_y = b.last_y;
      valid  = 1'b1;
      for (int k = 0; k < stall; k++) begin
         wr_full = 1'b1;
         @(negedge clk);
         check_out();
         chk("ready_stalled", 32'(ready), 32'd0);
         @(posedge clk);
         #1;
      end
      wr_full = 1'b0;
      @(negedge clk);
      check_out();
      chk("ready", 32'(ready), 32'd1);
      if (wr) begin
         e = '{addr: ea, data: b.colour, x: ex, y: ey, done: ed, sof: es, eol: ee};
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   // Clean pixels lo..hi of a frame, optionally stalling before pixel stall_at.
   task automatic frame_range(input int lo, input int hi, input int stall_at);
      pixel_beat_t b;
      for (int i = lo; i <= hi; i++) begin
         b.colour = CW'($urandom);
         b.first  = (i == 0);
         b.last_x = (i % W == W - 1);
         b.last_y = (i / W == H - 1);
         send(b, (i == stall_at) ? 3 : 0, 1'b1, i, i % W, i / W, i == W*H - 1, 1'b0, 1'b0);
      end
   endtask

   initial begin
      pixel_beat_t b;

      #2;
      chk("rst_ready",       32'(ready),       32'd0);
      chk("rst_wr_en",       32'(wr_en),       32'd0);
      chk("rst_wr_addr",     32'(wr_addr),     32'd0);
      chk("rst_wr_data",     32'(wr_data),     32'd0);
      chk("rst_xpixel",      xpixel,           32'd0);
      chk("rst_ypixel",      ypixel,           32'd0);
      chk("rst_pulses",      32'({frame_done, err_sof, err_eol}), 32'd0);
      chk("rst_frame_count", 32'(frame_count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // Clean frame
      frame_range(0, 11, -1);
      idle(2);
      chk("count_clean", 32'(frame_count), 32'd1);

      // Garbage before start of frame
      for (int i = 0; i < 5; i++) begin
         b = '{colour: CW'($urandom), first: 1'b0, last_x: (i == 3), last_y: 1'b0};
         send(b, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      end
      frame_range(0, 11, -1);
      idle(2);
      chk("count_garbage", 32'(frame_count), 32'd2);

      // Backpressure mid-line
      frame_range(0, 11, 5);
      idle(2);
      chk("count_backpressure", 32'(frame_count), 32'd3);

      // Early last_x at x=2 on line 0
      frame_range(0, 1, -1);
      b = '{colour: 24'h00AB12, first: 1'b0, last_x: 1'b1, last_y: 1'b0};
      send(b, 0, 1'b1, 2, 2, 0, 1'b0, 1'b0, 1'b1);
      frame_range(4, 11, -1);
      idle(2);
      chk("count_early_eol", 32'(frame_count), 32'd4);

      // first at (1,1)
      frame_range(0, 4, -1);
      b = '{colour: 24'h5A5A5A, first: 1'b1, last_x: 1'b0, last_y: 1'b0};
      send(b, 0, 1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b0);
      idle(2);
      chk("count_after_sof", 32'(frame_count), 32'd4);
      frame_range(1, 11, -1);
      idle(2);
      chk("count_sof_frame", 32'(frame_count), 32'd5);

      // Reset mid-frame at pixel 6
      frame_range(0, 5, -1);
      idle(1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready",       32'(ready),       32'd0);
      chk("mid_rst_wr_en",       32'(wr_en),       32'd0);
      chk("mid_rst_wr_addr",     32'(wr_addr),     32'd0);
      chk("mid_rst_wr_data",     32'(wr_data),     32'd0);
      chk("mid_rst_xy",          xpixel | ypixel,  32'd0);
      chk("mid_rst_frame_count", 32'(frame_count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      b = '{colour: 24'h123456, first: 1'b0, last_x: 1'b0, last_y: 1'b0};
      send(b, 0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      frame_range(0, 11, -1);
      idle(2);
      chk("count_after_reset", 32'(frame_count), 32'd1);
      chk("scoreboard_empty",  32'(sb.size()),   32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_stream_sink.md
# pixel_stream_sink

- Receives the pixel video stream produced by the queue/combinator path: colour plus `first`/`last_x`/`last_y` framing, under a `valid`/`ready` handshake.
- Rebuilds each accepted pixel's (x, y) position, checks the framing against the configured image size, and writes every pixel into a linear frame buffer port.
- Sits at the consumer end of the pixel interface, in place of the video output IP, for bench checking and frame capture.

## Interface
- `DATA_WIDTH`, 32, width of coordinate outputs
- `RBG_SIZE`, 24, colour width
- `IMAGE_WIDTH`, 640, pixels per line
- `IMAGE_HEIGHT`, 480, lines per frame
- `ADDR_WIDTH`, $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), frame buffer address width
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `colour_i`  in  RBG_SIZE  pixel colour
- `first`  in  1  beat is pixel (0,0) of a frame
- `last_x`  in  1  beat is last pixel of a line
- `last_y`  in  1  beat is on last line
- `valid`  in  1  beat present
- `ready`  out  1  sink can accept a beat
- `wr_full`  in  1  frame buffer cannot take a write this cycle
- `wr_en`  out  1  frame buffer write strobe
- `wr_addr`  out  ADDR_WIDTH  y*IMAGE_WIDTH + x
- `wr_data`  out  RBG_SIZE  colour written
- `xpixel_o`  out  DATA_WIDTH  x of last written pixel
- `ypixel_o`  out  DATA_WIDTH  y of last written pixel
- `frame_done`  out  1  one-cycle pulse, complete frame written
- `err_sof`  out  1  one-cycle pulse, `first` arrived mid-frame
- `err_eol`  out  1  one-cycle pulse, `last_x` mismatched x position
- `frame_count`  out  16  completed frames, wraps at 65535→0

## Operation
- Accept: `valid && ready`. `ready = !wr_full && !reset_active` (combinational from `wr_full`).
- FSM states: WAIT_SOF, ACTIVE.
- WAIT_SOF:
  - Accepted beats with `first=0` are discarded: no write, no error.
  - An accepted beat with `first=1` is written at (0,0), and the FSM moves to ACTIVE.
- ACTIVE:
  - Each accepted beat is written at the current (x,y). x increments; at x=IMAGE_WIDTH-1, x←0 and y increments.
  - `last_x` is expected exactly when x=IMAGE_WIDTH-1. On a mismatch, `err_eol` pulses and the pixel is still written. The line count is forced from the stream: if `last_x=1`, the next pixel goes to (0, y+1).
  - If `first=1` arrives while (x,y)≠(0,0), `err_sof` pulses and the beat is written at (0,0). The frame restarts; `frame_count` is unchanged.
  - The pixel at x=IMAGE_WIDTH-1, y=IMAGE_HEIGHT-1 with `last_x && last_y` completes the frame:
    - `frame_done` pulses and `frame_count` increments.
    - The FSM returns to WAIT_SOF.
  - If that last position is reached without `last_y`, `err_eol` pulses and the FSM returns to WAIT_SOF.
- Address arithmetic: `wr_addr` comes from an incremental counter, with no multiplier.
  - The counter resets to 0 on `first`.
  - On a forced early `last_x`, it is set to (y+1)*IMAGE_WIDTH using a registered line-base accumulator that adds IMAGE_WIDTH per line.

## Timing
- Reset values:
  - `ready`=0
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0
  - `xpixel_o`=0, `ypixel_o`=0
  - `frame_done`=0, `err_sof`=0, `err_eol`=0
  - `frame_count`=0
  - FSM=WAIT_SOF, x=y=0
- Latency: an accept in cycle N gives `wr_en`/`wr_addr`/`wr_data`/`xpixel_o`/`ypixel_o` registered in cycle N+1.
  - `frame_done` and the error pulses are coincident with that write.
- `wr_full` high in cycle N: `ready`=0 in N, no accept. A write already registered in N is presented regardless, because the frame buffer tolerates one in-flight write.
- Throughput: one pixel per cycle when `valid=1` and `wr_full=0`.
- Simultaneous `err_sof` and `err_eol` on one beat: both pulse.
- Reset asserted mid-frame: all state is cleared immediately and asynchronously, and the partial frame is abandoned. After release, the sink waits for `first`.

## Structure
- Shared package `pixel_pkg`:
  - FSM enum `sink_state_t` {WAIT_SOF, ACTIVE}
  - Default image dimension constants
  - Pixel beat struct (colour, first, last_x, last_y)
- Sub-module `pixel_position_counter`:
  - Holds the x/y/address counters and the line-base accumulator.
  - Inputs: advance, restart, force-next-line.
  - Outputs: x, y, addr, end-of-line, end-of-frame.
- The top level holds the FSM, the checks and the output registers.

## Test plan
- Run with IMAGE_WIDTH=4, IMAGE_HEIGHT=3.
- Clean frame: 12 beats, `first` on beat 0, `last_x` on beats 3/7/11, `last_y` on 8–11 → `wr_addr` 0..11 in order, `frame_done` on the 12th write, `frame_count`=1.
- Pre-SOF garbage: 5 beats with `first=0`, then a clean frame → no writes for the 5, then addresses 0..11.
- Backpressure: `wr_full`=1 for 3 cycles mid-line with `valid` held → `ready`=0 in those cycles, no address skipped or duplicated, 12 writes total.
- Early `last_x` at x=2 on line 0 → `err_eol` pulse at `wr_addr`=2; next write at `wr_addr`=4 with (x,y)=(0,1).
- `first` at position (1,1) → `err_sof` pulse, that beat written at `wr_addr`=0, `frame_count` unchanged.
- Reset low for 1 cycle at pixel 6, then a clean frame → all outputs 0 during reset, sink in WAIT_SOF after release, and the following frame completes with `frame_count`=1.
